// File: rtl/tp_pkg.sv
// Shared constants and state type for the transpose row feeder.
// Row, sample and drain geometry of the 8x8 transpose memory.
package tp_pkg;

    localparam int TP_N     = 8;
    localparam int TP_DRAIN = 8;
    localparam int CNT_W    = 3;

    typedef enum logic {
        FILL,
        DRAIN
    } tp_state_t;

endpackage

// File: rtl/tp_row_feeder_if.sv
// Sample-in / row-out bundle of the transpose row feeder.
// The producer/bench side holds master; the feeder holds slave.
interface tp_row_feeder_if #(
    parameter int BW = 12
);

    logic [BW-1:0]   i_sample;
    logic            i_valid;
    logic            o_ready;
    logic [8*BW-1:0] o_data;
    logic            o_en;
    logic            o_busy;

    modport master (
        output i_sample,
        output i_valid,
        input  o_ready,
        input  o_data,
        input  o_en,
        input  o_busy
    );

    modport slave (
        input  i_sample,
        input  i_valid,
        output o_ready,
        output o_data,
        output o_en,
        output o_busy
    );

endinterface

// File: rtl/tp_shift_packer.sv
// Shifts accepted samples into an 8-sample row, first sample in the MSB slice.
// Flags the accept that completes a row and presents the completed row.
module tp_shift_packer
    import tp_pkg::*;
#(
    parameter int BW = 12
) (
    input  logic               i_clk,
    input  logic               i_Reset,
    input  logic               accept,
    input  logic [BW-1:0]      sample,
    output logic [CNT_W-1:0]   samp_cnt,
    output logic               row_done,
    output logic [TP_N*BW-1:0] row
);

    logic [TP_N*BW-1:0] shift;

    assign row      = {shift[(TP_N-1)*BW-1:0], sample};
    assign row_done = accept && (samp_cnt == CNT_W'(TP_N - 1));

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            shift    <= '0;
            samp_cnt <= '0;
        end else if (accept) begin
            shift    <= row;
            samp_cnt <= samp_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tp_row_feeder.sv
// Packs serial samples into rows for the 8x8 transpose memory and holds
// off emission for the read-out window after every 8th row.
module tp_row_feeder
    import tp_pkg::*;
#(
    parameter int BW = 12
) (
    input  logic             i_clk,
    input  logic             i_Reset,
    tp_row_feeder_if.slave   bus
);

    tp_state_t          state;
    tp_state_t          state_n;
    logic [CNT_W-1:0]   samp_cnt;
    logic [CNT_W-1:0]   row_cnt;
    logic [CNT_W-1:0]   drain_cnt;
    logic               row_done;
    logic [TP_N*BW-1:0] row;
    logic [TP_N*BW-1:0] row_buf;
    logic               row_full;
    logic               accept;
    logic               emit;
    logic               en_q;
    logic [TP_N*BW-1:0] data_q;
    logic               busy_q;

    // Only the 8th sample of a row needs a free buffer.
    assign bus.o_ready = !(row_full && (samp_cnt == CNT_W'(TP_N - 1)));
    assign accept      = bus.i_valid && bus.o_ready && !i_Reset;

    assign bus.o_en    = en_q;
    assign bus.o_data  = data_q;
    assign bus.o_busy  = busy_q;

    tp_shift_packer #(
        .BW(BW)
    ) u_packer (
        .i_clk    (i_clk),
        .i_Reset  (i_Reset),
        .accept   (accept),
        .sample   (bus.i_sample),
        .samp_cnt (samp_cnt),
        .row_done (row_done),
        .row      (row)
    );

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        emit    = 1'b0;
        case (state)
            FILL: begin
                emit = row_full;
                if (row_full && (row_cnt == CNT_W'(TP_N - 1))) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == CNT_W'(TP_DRAIN - 1)) begin
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // A row can only complete while row_buf is empty, so set and clear never collide.
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            row_buf   <= '0;
            row_full  <= 1'b0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            en_q      <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            en_q   <= emit;
            data_q <= emit ? row_buf : '0;
            busy_q <= (state == DRAIN);
            if (row_done) begin
                row_buf  <= row;
                row_full <= 1'b1;
            end else if (emit) begin
                row_full <= 1'b0;
            end
            if (emit) begin
                row_cnt <= row_cnt + 1'b1;
            end
            if (emit && (row_cnt == CNT_W'(TP_N - 1))) begin
                drain_cnt <= '0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tp_row_feeder.sv
// Directed bench for tp_row_feeder: packing, block drain spacing, reset.
module tb_tp_row_feeder;

    localparam int BW   = 12;
    localparam int RW   = 8 * BW;
    localparam int HIST = 2048;

    typedef struct {
        int           cyc;
        logic [RW-1:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bad_zero = 0;
    int   last_acc = 0;
    ev_t  ev[$];
    logic busy_hist[HIST];

    tp_row_feeder_if #(.BW(BW)) bus ();

    tp_row_feeder #(.BW(BW)) dut (
        .i_clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_en === 1'b1) begin
            ev.push_back('{cyc, bus.o_data});
        end else if (bus.o_data !== '0) begin
            bad_zero++;
        end
        if (cyc < HIST) busy_hist[cyc] = bus.o_busy;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [BW-1:0] s);
        int t = 0;
        bus.i_valid  = 1'b1;
        bus.i_sample = s;
        while (bus.o_ready !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 40) begin
            errors++;
            $display("FAIL push_timeout sample=%h ready stayed %b", s, bus.o_ready);
        end
        last_acc = cyc;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    function automatic logic [RW-1:0] row_of(input int base);
        logic [RW-1:0] r = '0;
        for (int j = 0; j < 8; j++) r = {r[RW-BW-1:0], BW'(base + j)};
        return r;
    endfunction

    task automatic test_reset();
        rst          = 1'b1;
        bus.i_valid  = 1'b1;
        bus.i_sample = 12'hABC;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.o_en !== 1'b0) begin
            errors++; $display("FAIL rst_en got %b want 0", bus.o_en);
        end
        checks++;
        if (bus.o_data !== '0) begin
            errors++; $display("FAIL rst_data got %h want 0", bus.o_data);
        end
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy got %b want 0", bus.o_busy);
        end
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got %b want 1", bus.o_ready);
        end
        rst         = 1'b0;
        bus.i_valid = 1'b0;
        ev.delete();
        bad_zero = 0;
        idle(12);
        checks++;
        if (ev.size() != 0) begin
            errors++; $display("FAIL rst_no_row got %0d rows want 0", ev.size());
        end
    endtask

    task automatic test_one_block();
        int acc8 = 0;
        ev.delete();
        for (int i = 0; i < 64; i++) begin
            push(BW'(i));
            if (i == 7) acc8 = last_acc;
        end
        idle(14);
        checks++;
        if (ev.size() != 8) begin
            errors++; $display("FAIL blk1_rows got %0d want 8", ev.size());
        end
        if (ev.size() == 8) begin
            checks++;
            if (ev[0].cyc - acc8 != 2) begin
                errors++;
                $display("FAIL blk1_latency got %0d want 2", ev[0].cyc - acc8);
            end
            for (int r = 0; r < 8; r++) begin
                checks++;
                if (ev[r].d !== row_of(8 * r)) begin
                    errors++;
                    $display("FAIL blk1_row%0d got %h want %h", r, ev[r].d, row_of(8 * r));
                end
                if (r > 0) begin
                    checks++;
                    if (ev[r].cyc - ev[r-1].cyc != 8) begin
                        errors++;
                        $display("FAIL blk1_gap%0d got %0d want 8", r, ev[r].cyc - ev[r-1].cyc);
                    end
                end
            end
            for (int k = 0; k <= 9; k++) begin
                logic want;
                want = (k >= 1 && k <= 8);
                checks++;
                if (busy_hist[ev[7].cyc + k] !== want) begin
                    errors++;
                    $display("FAIL blk1_busy+%0d got %b want %b", k, busy_hist[ev[7].cyc + k], want);
                end
            end
        end
    endtask

    task automatic test_two_blocks();
        ev.delete();
        for (int i = 0; i < 128; i++) push(BW'(i));
        idle(20);
        checks++;
        if (ev.size() != 16) begin
            errors++; $display("FAIL blk2_rows got %0d want 16", ev.size());
        end
        if (ev.size() == 16) begin
            checks++;
            if (ev[8].cyc - ev[7].cyc != 9) begin
                errors++;
                $display("FAIL blk2_gap got %0d want 9", ev[8].cyc - ev[7].cyc);
            end
            for (int r = 0; r < 16; r++) begin
                checks++;
                if (ev[r].d !== row_of(8 * r)) begin
                    errors++;
                    $display("FAIL blk2_row%0d got %h want %h", r, ev[r].d, row_of(8 * r));
                end
            end
            for (int k = 1; k <= 8; k++) begin
                checks++;
                if (busy_hist[ev[7].cyc + k] !== 1'b1) begin
                    errors++;
                    $display("FAIL blk2_busy+%0d got %b want 1", k, busy_hist[ev[7].cyc + k]);
                end
            end
        end
    endtask

    task automatic test_sparse();
        ev.delete();
        for (int i = 1; i <= 8; i++) begin
            push(BW'(i));
            if (i < 8) idle(1);
        end
        idle(6);
        checks++;
        if (ev.size() != 1) begin
            errors++; $display("FAIL sparse_rows got %0d want 1", ev.size());
        end
        if (ev.size() == 1) begin
            checks++;
            if (ev[0].d !== 96'h001_002_003_004_005_006_007_008) begin
                errors++; $display("FAIL sparse_row got %h want 001002003004005006007008", ev[0].d);
            end
            checks++;
            if (ev[0].cyc - last_acc != 2) begin
                errors++; $display("FAIL sparse_latency got %0d want 2", ev[0].cyc - last_acc);
            end
        end
    endtask

    task automatic test_reset_mid_row();
        ev.delete();
        for (int i = 0; i < 5; i++) push(BW'(12'h0F0 + i));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 100; i < 108; i++) push(BW'(i));
        idle(6);
        checks++;
        if (ev.size() != 1) begin
            errors++; $display("FAIL midrst_rows got %0d want 1", ev.size());
        end
        if (ev.size() == 1) begin
            checks++;
            if (ev[0].d !== row_of(100)) begin
                errors++; $display("FAIL midrst_row got %h want %h", ev[0].d, row_of(100));
            end
        end
    endtask

    task automatic test_full_scale();
        ev.delete();
        bad_zero = 0;
        for (int i = 0; i < 8; i++) push((i % 2 == 0) ? 12'hFFF : 12'h000);
        idle(6);
        checks++;
        if (ev.size() != 1) begin
            errors++; $display("FAIL full_rows got %0d want 1", ev.size());
        end
        if (ev.size() == 1) begin
            checks++;
            if (ev[0].d !== 96'hFFF000FFF000FFF000FFF000) begin
                errors++; $display("FAIL full_row got %h want FFF000FFF000FFF000FFF000", ev[0].d);
            end
        end
        checks++;
        if (bad_zero != 0) begin
            errors++; $display("FAIL idle_data_zero got %0d nonzero cycles want 0", bad_zero);
        end
    endtask

    initial begin
        bus.i_valid  = 1'b0;
        bus.i_sample = '0;
        test_reset();
        test_one_block();
        test_two_blocks();
        test_sparse();
        test_reset_mid_row();
        test_full_scale();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
